// File: rtl/vs_uart_pkg.sv
// Shared constants, state encoding and parity helper for the vs_uart core.
package vs_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OVS = 16;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} uart_st_e;

    // Parity bit value for a word whose XOR-reduction is ones_odd.
    function automatic logic par_bit(input logic ones_odd, input int mode);
        return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
    endfunction

endpackage

// File: rtl/vs_uart_fifo.sv
// Synchronous FIFO; push and pop in the same cycle both succeed even when full.
module vs_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
        // Head reads as zero when empty so nothing stale leaks out of reset.
        rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/vs_uart_core_p.sv
// UART core with TX/RX FIFOs. Define VS_UART_ERR_INJ_EN to add the
// INJ_FRM_ERR / INJ_PAR_ERR error-injection inputs.
module vs_uart_core_p
    import vs_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              CLK,
    input  logic              SYS_NRST,
    input  logic              RXD,
    output logic              TXD,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic [DATA_W-1:0] RX_DATA,
    output logic [1:0]        RX_ERR,
    output logic              RX_VALID,
    input  logic              RX_READY,
    output logic              RX_OVR
`ifdef VS_UART_ERR_INJ_EN
    ,
    input  logic              INJ_FRM_ERR,
    input  logic              INJ_PAR_ERR
`endif
);
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int TICK_CYC = CLK_FREQ / (OVS * BAUD);
    localparam int CW       = $clog2(BIT_CYC + 1);
    localparam int TW       = $clog2(TICK_CYC + 1);

    logic inj_frm, inj_par;
`ifdef VS_UART_ERR_INJ_EN
    assign inj_frm = INJ_FRM_ERR;
    assign inj_par = INJ_PAR_ERR;
`else
    assign inj_frm = 1'b0;
    assign inj_par = 1'b0;
`endif

    // ---------------- TX ----------------
    logic              rdy_q, tx_full, tx_empty, tx_pop, tx_load, tx_bit_end;
    logic [DATA_W-1:0] tx_head, tx_sh_q, tx_sh_d;
    uart_st_e          tx_st_q, tx_st_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_idx_q, tx_idx_d;
    logic              tx_par_q, tx_par_d, tx_frm_q, tx_frm_d, txd_q, txd_d;

    // rdy_q holds TX_READY low through reset and releases it on the first edge after.
    assign TX_READY = rdy_q && !tx_full;
    assign TXD      = txd_q;

    vs_uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(CLK), .rst_n(SYS_NRST), .push_i(TX_VALID && TX_READY), .wdata_i(TX_DATA),
        .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
    );

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_frm_d   = tx_frm_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        tx_bit_end = (tx_cnt_q == CW'(BIT_CYC - 1));
        unique case (tx_st_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_load  = !tx_empty;
            end
            ST_START: if (tx_bit_end) begin
                tx_st_d  = ST_DATA;
                tx_cnt_d = '0;
                tx_idx_d = '0;
                txd_d    = tx_sh_q[0];
                tx_sh_d  = tx_sh_q >> 1;
            end
            ST_DATA: if (tx_bit_end) begin
                tx_cnt_d = '0;
                if (tx_idx_q == 4'(DATA_W - 1)) begin
                    tx_idx_d = '0;
                    tx_st_d  = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    txd_d    = (PARITY != PAR_NONE) ? tx_par_q : !tx_frm_q;
                end else begin
                    tx_idx_d = tx_idx_q + 4'd1;
                    txd_d    = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                end
            end
            ST_PAR: if (tx_bit_end) begin
                tx_cnt_d = '0;
                tx_st_d  = ST_STOP;
                txd_d    = !tx_frm_q;
            end
            ST_STOP: if (tx_bit_end) begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (tx_idx_q == 4'(STOP_BITS - 1)) begin
                    tx_st_d = ST_IDLE;
                    tx_load = !tx_empty;
                end else begin
                    tx_idx_d = tx_idx_q + 4'd1;
                end
            end
            default: tx_st_d = ST_IDLE;
        endcase
        // Loading straight out of the last stop bit keeps back-to-back frames gapless.
        if (tx_load) begin
            tx_pop   = 1'b1;
            tx_st_d  = ST_START;
            tx_cnt_d = '0;
            txd_d    = 1'b0;
            tx_sh_d  = tx_head;
            tx_par_d = par_bit(^tx_head, PARITY) ^ inj_par;
            tx_frm_d = inj_frm;
        end
    end

    // ---------------- RX ----------------
    logic                rxs1_q, rxs2_q, rxp_q, rx_tick, rx_mid, rx_push, rx_drop, ovr_q;
    logic                rx_full, rx_empty;
    uart_st_e            rx_st_q, rx_st_d;
    logic [TW-1:0]       tk_q, tk_d;
    logic [3:0]          ovs_q, ovs_d, rx_idx_q, rx_idx_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic                rx_perr_q, rx_perr_d;
    logic [DATA_W+1:0]   rx_word, rx_head;

    assign rx_tick  = (tk_q == TW'(TICK_CYC - 1));
    assign rx_mid   = rx_tick && (ovs_q == 4'(OVS - 1));
    assign rx_word  = {!rxs2_q, rx_perr_q, rx_sh_q};
    assign rx_drop  = rx_push && rx_full && !(RX_READY && RX_VALID);
    assign RX_VALID = !rx_empty;
    assign RX_DATA  = rx_head[DATA_W-1:0];
    assign RX_ERR   = rx_head[DATA_W+1:DATA_W];
    assign RX_OVR   = ovr_q;

    vs_uart_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(CLK), .rst_n(SYS_NRST), .push_i(rx_push), .wdata_i(rx_word),
        .pop_i(RX_READY), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        rx_st_d   = rx_st_q;
        ovs_d     = rx_tick ? ovs_q + 4'd1 : ovs_q;
        tk_d      = rx_tick ? '0 : tk_q + TW'(1);
        rx_idx_d  = rx_idx_q;
        rx_sh_d   = rx_sh_q;
        rx_perr_d = rx_perr_q;
        rx_push   = 1'b0;
        unique case (rx_st_q)
            ST_IDLE: begin
                ovs_d = '0;
                // Tick phase restarts on the falling edge so samples land mid-bit.
                if (rxp_q && !rxs2_q) begin
                    rx_st_d   = ST_START;
                    tk_d      = '0;
                    rx_idx_d  = '0;
                    rx_perr_d = 1'b0;
                end
            end
            ST_START: if (rx_tick && ovs_q == 4'(OVS / 2 - 1)) begin
                ovs_d   = '0;
                rx_st_d = rxs2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_mid) begin
                rx_sh_d  = {rxs2_q, rx_sh_q[DATA_W-1:1]};
                rx_idx_d = rx_idx_q + 4'd1;
                if (rx_idx_q == 4'(DATA_W - 1))
                    rx_st_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end
            ST_PAR: if (rx_mid) begin
                rx_perr_d = (rxs2_q != par_bit(^rx_sh_q, PARITY));
                rx_st_d   = ST_STOP;
            end
            ST_STOP: if (rx_mid) begin
                rx_push = 1'b1;
                rx_st_d = ST_IDLE;
            end
            default: rx_st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            rdy_q     <= 1'b0;
            tx_st_q   <= ST_IDLE;
            tx_cnt_q  <= '0;
            tx_idx_q  <= '0;
            tx_sh_q   <= '0;
            tx_par_q  <= 1'b0;
            tx_frm_q  <= 1'b0;
            txd_q     <= 1'b1;
            rxs1_q    <= 1'b1;
            rxs2_q    <= 1'b1;
            rxp_q     <= 1'b1;
            rx_st_q   <= ST_IDLE;
            tk_q      <= '0;
            ovs_q     <= '0;
            rx_idx_q  <= '0;
            rx_sh_q   <= '0;
            rx_perr_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rdy_q     <= 1'b1;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_idx_q  <= tx_idx_d;
            tx_sh_q   <= tx_sh_d;
            tx_par_q  <= tx_par_d;
            tx_frm_q  <= tx_frm_d;
            txd_q     <= txd_d;
            rxs1_q    <= RXD;
            rxs2_q    <= rxs1_q;
            rxp_q     <= rxs2_q;
            rx_st_q   <= rx_st_d;
            tk_q      <= tk_d;
            ovs_q     <= ovs_d;
            rx_idx_q  <= rx_idx_d;
            rx_sh_q   <= rx_sh_d;
            rx_perr_q <= rx_perr_d;
            ovr_q     <= rx_drop;
        end
    end

endmodule

// File: tb/tb_vs_uart_core_p.sv
// Scoreboard bench: stimulus pushes expected RX words, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vs_uart_core_p;
    localparam int CF = 6400, BD = 100, DW = 8, BIT = CF / BD;
    localparam int BIT0 = 100000000 / 115200;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          txd, rxd, rxd_drv = 1'b1, loop = 1'b0;
    logic [DW-1:0] tx_data = '0, rx_data;
    logic          tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0, rx_ovr;
    logic [1:0]    rx_err;
    assign rxd = loop ? txd : rxd_drv;

    logic       txd0, tx_ready0, rx_valid0, rx_ovr0, tx_valid0 = 1'b0;
    logic [7:0] tx_data0 = '0, rx_data0;
    logic [1:0] rx_err0;
`ifdef VS_UART_ERR_INJ_EN
    logic inj_frm = 1'b0, inj_par = 1'b0;
`endif

    vs_uart_core_p #(.CLK_FREQ(CF), .BAUD(BD), .DATA_W(DW), .PARITY(1), .STOP_BITS(2),
                     .FIFO_DEPTH(4)) dut (
        .CLK(clk), .SYS_NRST(rst_n), .RXD(rxd), .TXD(txd), .TX_DATA(tx_data),
        .TX_VALID(tx_valid), .TX_READY(tx_ready), .RX_DATA(rx_data), .RX_ERR(rx_err),
        .RX_VALID(rx_valid), .RX_READY(rx_ready), .RX_OVR(rx_ovr)
`ifdef VS_UART_ERR_INJ_EN
        , .INJ_FRM_ERR(inj_frm), .INJ_PAR_ERR(inj_par)
`endif
    );

    vs_uart_core_p dut0 (
        .CLK(clk), .SYS_NRST(rst_n), .RXD(1'b1), .TXD(txd0), .TX_DATA(tx_data0),
        .TX_VALID(tx_valid0), .TX_READY(tx_ready0), .RX_DATA(rx_data0), .RX_ERR(rx_err0),
        .RX_VALID(rx_valid0), .RX_READY(1'b0), .RX_OVR(rx_ovr0)
`ifdef VS_UART_ERR_INJ_EN
        , .INJ_FRM_ERR(1'b0), .INJ_PAR_ERR(1'b0)
`endif
    );

    int tests = 0, fails = 0, ovr_cyc = 0;
    bit rand_rdy = 1'b0;
    logic [DW+1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted RX word must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rx_ovr) ovr_cyc++;
        if (rst_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got 0x%0h, want nothing", {rx_err, rx_data});
            end else begin
                chk("rx_word", {22'd0, rx_err, rx_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rdy) rx_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send_tx(input logic [DW-1:0] w);
        int n = 0;
        while (!tx_ready && n < 4000) begin tick(); n++; end
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_fall(input string name);
        int n = 0;
        while (txd !== 1'b0 && n < 3000) begin tick(); n++; end
        chk(name, {31'd0, txd}, 32'd0);
    endtask

    // Even parity, two stop bits; the expected word is queued only when it should be kept.
    task automatic send_rx(input logic [DW-1:0] w, input bit bad_par, input bit bad_stop,
                           input bit keep);
        logic [11:0] fr;
        fr = {1'b1, ~bad_stop, (^w) ^ bad_par, w, 1'b0};
        if (keep) exp_q.push_back({bad_stop, bad_par, w});
        for (int b = 0; b < 12; b++) begin
            rxd_drv = fr[b];
            tick(BIT);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin tick(); n++; end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f0;
        logic [DW-1:0] w;
        int bad, o0;

        // Reset values
        tick(3);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_ovr", {31'd0, rx_ovr}, 32'd0);
        chk("rst_rx_word", {22'd0, rx_err, rx_data}, 32'd0);
        chk("rst0_txd", {31'd0, txd0}, 32'd1);
        chk("rst0_tx_ready", {31'd0, tx_ready0}, 32'd0);
        chk("rst0_rx", {20'd0, rx_ovr0, rx_valid0, rx_err0, rx_data0}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rel0_tx_ready", {31'd0, tx_ready0}, 32'd1);

        // Default-parameter frame timing for 0xA5
        f0 = {1'b1, 8'hA5, 1'b0};
        tx_data0  = 8'hA5;
        tx_valid0 = 1'b1;
        tick();
        tx_valid0 = 1'b0;
        bad = 0;
        while (txd0 !== 1'b0 && bad < 100) begin tick(); bad++; end
        chk("tx0_start", {31'd0, txd0}, 32'd0);
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            repeat (BIT0) begin
                if (txd0 !== f0[b]) bad++;
                tick();
            end
            chk($sformatf("tx0_bit%0d", b), bad, 32'd0);
        end
        chk("tx0_idle", {31'd0, txd0}, 32'd1);

        // Loopback with random consumer backpressure
        loop = 1'b1;
        rand_rdy = 1'b1;
        exp_q.push_back({2'b00, 8'h07});
        send_tx(8'h07);
        wait_fall("lb_start_07");
        tick(9 * BIT + BIT / 2);
        chk("par_bit_07", {31'd0, txd}, 32'd1);
        for (int i = 0; i < 18; i++) begin
            w = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
            exp_q.push_back({2'b00, w});
            send_tx(w);
        end
        wait_drain(30000);

        // Directly driven RX frames: framing error, parity error, glitch
        loop = 1'b0;
        rand_rdy = 1'b0;
        rx_ready = 1'b1;
        send_rx(8'h3C, 1'b0, 1'b1, 1'b1);
        send_rx(8'($urandom), 1'b1, 1'b0, 1'b1);
        wait_drain(2000);
        rxd_drv = 1'b0;
        tick(20);
        rxd_drv = 1'b1;
        tick(3 * BIT);
        chk("glitch_rx_valid", {31'd0, rx_valid}, 32'd0);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_drain(2000);

        // Overflow: four kept, fifth dropped with one RX_OVR cycle
        rx_ready = 1'b0;
        o0 = ovr_cyc;
        for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b0, 1'b0, i < 4);
        tick(10);
        chk("ovr_pulse_cycles", ovr_cyc - o0, 32'd1);
        chk("rx_valid_full", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        wait_drain(100);
        tick(5);
        chk("rx_empty_after", {31'd0, rx_valid}, 32'd0);

        // Reset in the middle of DATA with a second word still queued
        loop = 1'b1;
        send_tx(8'hC3);
        send_tx(8'h3C);
        wait_fall("abort_start");
        tick(3 * BIT);
        rst_n = 1'b0;
        #1;
        chk("abort_txd", {31'd0, txd}, 32'd1);
        chk("abort_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        w = 8'($urandom);
        exp_q.push_back({2'b00, w});
        send_tx(w);
        wait_drain(3000);
        tick(14 * BIT);
        chk("abort_no_stale", {31'd0, rx_valid}, 32'd0);

`ifdef VS_UART_ERR_INJ_EN
        exp_q.push_back({2'b01, 8'h00});
        inj_par = 1'b1;
        send_tx(8'h00);
        wait_fall("inj_par_start");
        inj_par = 1'b0;
        exp_q.push_back({2'b10, 8'hA5});
        inj_frm = 1'b1;
        send_tx(8'hA5);
        wait_fall("inj_frm_start");
        inj_frm = 1'b0;
        wait_drain(4000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vs_uart_core_p.md
VS_UART_CORE_P -- requirements
Module: vs_uart_core_p

Interface
REQ-001 The module SHALL expose these parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_W, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits: 1 or 2.
- FIFO_DEPTH, 16, entries per FIFO; power of 2, at least 2.

REQ-002 The module SHALL have these ports:
- CLK  in  1  system clock.
- SYS_NRST  in  1  asynchronous active-low reset.
- RXD  in  1  serial input, asynchronous to CLK.
- TXD  out  1  serial output.
- TX_DATA  in  DATA_W  word to transmit.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  TX FIFO not full.
- RX_DATA  out  DATA_W  head of RX FIFO.
- RX_ERR  out  2  {frame error, parity error} of the RX_DATA word.
- RX_VALID  out  1  RX FIFO not empty.
- RX_READY  in  1  consumer accepts the RX_DATA word.
- RX_OVR  out  1  one-cycle pulse when a received word is dropped.

REQ-003 Clocking and reset: one clock, CLK. Reset is asynchronous and active-low, on SYS_NRST.

Function
REQ-004 A word SHALL be transferred only on a CLK edge where VALID and READY are both high; TX_READY and RX_VALID SHALL NOT depend combinationally on TX_VALID or RX_READY.
REQ-005 The bit period SHALL be CLK_FREQ/BAUD cycles (integer division); RX SHALL use a 16x oversample tick of CLK_FREQ/(16*BAUD) cycles.
REQ-006 The TX FSM SHALL have the states IDLE, START, DATA, PAR, STOP:
- frame order: start 0, DATA_W bits LSB first, parity bit (PAR state) only if PARITY!=0, then STOP_BITS stop bits of 1;
- PAR is skipped when PARITY=0;
- each bit lasts exactly one bit period.
REQ-007 TX SHALL pop the TX FIFO in IDLE when it is non-empty; the start bit SHALL appear on TXD the cycle after the pop, with the bit timer restarted.
REQ-008 After the last stop bit, TX SHALL return to IDLE; back-to-back frames SHALL have no extra idle bit.
REQ-009 RXD SHALL pass through a 2-FF synchroniser. The RX FSM SHALL have the states IDLE, START, DATA, PAR, STOP:
- a falling edge in IDLE enters START;
- at the mid-start sample (8 ticks), RXD=1 is a false start and returns to IDLE with nothing stored;
- every later bit is sampled at mid-bit (every 16 ticks).
REQ-010 RX SHALL check only the first stop bit:
- stop sample 0 sets frame error;
- a parity mismatch sets parity error;
- the word and both error flags SHALL be pushed together, even when erroneous.
REQ-011 If the RX FIFO is full at push time and no pop occurs in the same cycle, the word SHALL be dropped and RX_OVR SHALL pulse high for exactly one cycle.
REQ-012 Simultaneous push and pop SHALL both succeed at any occupancy, including full and empty, leaving the count unchanged; on empty, the pop is ignored.
REQ-013 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-014 RX_DATA and RX_ERR SHALL be stable while RX_VALID=1 and RX_READY=0.

Reset
REQ-015 While SYS_NRST=0, outputs SHALL be:
- TXD=1;
- TX_READY=0;
- RX_VALID=0, RX_OVR=0;
- RX_DATA=0, RX_ERR=0.
REQ-016 While SYS_NRST=0, both FIFOs SHALL be empty and both FSMs in IDLE.
REQ-017 A reset during a frame SHALL abort the frame immediately, discarding any partial word; TX_READY SHALL go to 1 on the first CLK edge after reset is released.

Configuration
REQ-018 With macro VS_UART_ERR_INJ_EN defined, the module SHALL add inputs INJ_FRM_ERR (1 bit) and INJ_PAR_ERR (1 bit):
- INJ_FRM_ERR=1 at a frame start forces that frame's first stop bit to 0;
- INJ_PAR_ERR=1 at a frame start inverts that frame's parity bit; it has no effect when PARITY=0.
REQ-019 Without VS_UART_ERR_INJ_EN, the INJ_FRM_ERR and INJ_PAR_ERR ports SHALL NOT exist and frames SHALL always be well-formed.

Structure
REQ-020 The package vs_uart_pkg SHALL hold:
- the parity-mode constants;
- the shared TX/RX state enumeration;
- the oversample ratio constant (16).
REQ-021 The sub-module vs_uart_fifo (parameters WIDTH and DEPTH) SHALL be instantiated twice: TX with width DATA_W, RX with width DATA_W+2.

Verification
REQ-022 Defaults, TX 0xA5 -> TXD carries 0,1,0,1,0,0,1,0,1,1, each bit exactly 868 cycles.
REQ-023 PARITY=1, TXD looped to RXD, TX 0x07 -> parity bit 1; RX_DATA=0x07 with RX_ERR=00.
REQ-024 RXD frame 0x3C with stop bit 0 -> RX_DATA=0x3C, RX_ERR=10; a 300-cycle low glitch on RXD -> nothing stored.
REQ-025 FIFO_DEPTH=4, five frames received with RX_READY=0 -> first four retained in order, fifth dropped, one RX_OVR pulse.
REQ-026 With VS_UART_ERR_INJ_EN defined and PARITY=1, loopback 0x00 with INJ_PAR_ERR=1 -> RX_ERR=01.
REQ-027 SYS_NRST asserted in the middle of the DATA state -> TXD=1 at once, FIFOs empty, the next frame is transmitted correctly.
